// File: rtl/pipe_ctrl_unit_if.sv
// Control bundle between the 5-stage datapath and pipe_ctrl_unit.
// Optional macro PIPE_CTRL_PERF_EN adds the performance counter outputs.
interface pipe_ctrl_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [XLEN-1:0]       id_x17;
  logic                  ex_flush;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  id_stall;
  logic                  ex_alu_src;
  logic [1:0]            ex_alu_op;
  logic                  ex_is_branch;
  logic                  ex_is_jal;
  logic                  ex_is_jalr;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  wb_mem_to_reg;
  logic                  wb_write_enable;
  logic                  wb_pc_to_reg;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  is_halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_x17, ex_flush,
    input  pc_write, ifid_write, id_stall,
    input  ex_alu_src, ex_alu_op, ex_is_branch, ex_is_jal, ex_is_jalr,
    input  mem_mem_read, mem_mem_write,
    input  wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd,
    input  is_halted, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_x17, ex_flush,
    output pc_write, ifid_write, id_stall,
    output ex_alu_src, ex_alu_op, ex_is_branch, ex_is_jal, ex_is_jalr,
    output mem_mem_read, mem_mem_write,
    output wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd,
    output is_halted, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_x17, ex_flush,
    input  pc_write, ifid_write, id_stall,
    input  ex_alu_src, ex_alu_op, ex_is_branch, ex_is_jal, ex_is_jalr,
    input  mem_mem_read, mem_mem_write,
    input  wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd,
    input  is_halted
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_x17, ex_flush,
    output pc_write, ifid_write, id_stall,
    output ex_alu_src, ex_alu_op, ex_is_branch, ex_is_jal, ex_is_jalr,
    output mem_mem_read, mem_mem_write,
    output wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd,
    output is_halted
  );
`endif
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, hazard bubbles, EX flush and ecall-halt drain FSM.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl_unit #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int HALT_CODE    = 10,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  write_enable;
    logic                  pc_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  write_enable;
    logic                  pc_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  write_enable;
    logic                  pc_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;

  ex_ctrl_t  r_idEx;
  mem_ctrl_t r_exMem;
  wb_ctrl_t  r_memWb;

  ex_ctrl_t  w_decoded;
  ex_ctrl_t  w_idExNext;
  logic      w_isEcall;
  logic      w_usesRs1;
  logic      w_usesRs2;
  logic      w_loadUse;
  logic      w_ecallHazard;
  logic      w_run;
  logic      w_idStall;
  logic      w_haltDetect;

  // ECALL decodes to an all-zero bundle so it travels down the pipe as a bubble.
  always_comb begin
    w_decoded = '0;
    w_isEcall = 1'b0;
    w_usesRs2 = 1'b0;
    unique case (bus.id_opcode)
      OP_LOAD: begin
        w_decoded.alu_src      = 1'b1;
        w_decoded.mem_read     = 1'b1;
        w_decoded.mem_to_reg   = 1'b1;
        w_decoded.write_enable = 1'b1;
      end
      OP_STORE: begin
        w_decoded.alu_src   = 1'b1;
        w_decoded.mem_write = 1'b1;
        w_usesRs2           = 1'b1;
      end
      OP_BRANCH: begin
        w_decoded.alu_op    = 2'b01;
        w_decoded.is_branch = 1'b1;
        w_usesRs2           = 1'b1;
      end
      OP_ARITH: begin
        w_decoded.alu_op       = 2'b10;
        w_decoded.write_enable = 1'b1;
        w_usesRs2              = 1'b1;
      end
      OP_ARITH_IMM: begin
        w_decoded.alu_src      = 1'b1;
        w_decoded.alu_op       = 2'b10;
        w_decoded.write_enable = 1'b1;
      end
      OP_JAL: begin
        w_decoded.alu_src      = 1'b1;
        w_decoded.is_jal       = 1'b1;
        w_decoded.pc_to_reg    = 1'b1;
        w_decoded.write_enable = 1'b1;
      end
      OP_JALR: begin
        w_decoded.alu_src      = 1'b1;
        w_decoded.is_jalr      = 1'b1;
        w_decoded.pc_to_reg    = 1'b1;
        w_decoded.write_enable = 1'b1;
      end
      OP_ECALL: begin
        w_isEcall = 1'b1;
      end
      default: begin
        w_isEcall = 1'b0;
      end
    endcase
    if (w_decoded.write_enable) begin
      w_decoded.rd = bus.id_rd;
    end
  end

  assign w_usesRs1 = (bus.id_opcode != OP_JAL);
  assign w_run     = (r_state == ST_RUN);

  // No forwarding into ID, so an ecall must wait until x17 has reached WB.
  assign w_loadUse = bus.id_valid && r_idEx.mem_read && (r_idEx.rd != '0) &&
                     ((w_usesRs1 && (bus.id_rs1 == r_idEx.rd)) ||
                      (w_usesRs2 && (bus.id_rs2 == r_idEx.rd)));

  assign w_ecallHazard = bus.id_valid && w_isEcall &&
                         ((r_idEx.write_enable  && (r_idEx.rd  == REG_ADDR_W'(17))) ||
                          (r_exMem.write_enable && (r_exMem.rd == REG_ADDR_W'(17))));

  assign w_idStall = reset && w_run && (w_loadUse || w_ecallHazard) && !bus.ex_flush;

  assign w_haltDetect = w_run && bus.id_valid && w_isEcall && !w_idStall &&
                        !bus.ex_flush && (bus.id_x17 == XLEN'(HALT_CODE));

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_haltDetect) begin
          w_stateNext = ST_DRAIN;
          w_cntNext   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_stateNext = ST_HALTED;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        w_stateNext = ST_HALTED;
      end
      default: begin
        w_stateNext = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Flush, drain/halt, stall and invalid ID all collapse to a bubble.
  always_comb begin
    w_idExNext = '0;
    if (w_run && !bus.ex_flush && !w_idStall && bus.id_valid) begin
      w_idExNext = w_decoded;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idEx  <= '0;
      r_exMem <= '0;
      r_memWb <= '0;
    end else begin
      r_idEx               <= w_idExNext;
      r_exMem.mem_read     <= r_idEx.mem_read;
      r_exMem.mem_write    <= r_idEx.mem_write;
      r_exMem.mem_to_reg   <= r_idEx.mem_to_reg;
      r_exMem.write_enable <= r_idEx.write_enable;
      r_exMem.pc_to_reg    <= r_idEx.pc_to_reg;
      r_exMem.rd           <= r_idEx.rd;
      r_memWb.mem_to_reg   <= r_exMem.mem_to_reg;
      r_memWb.write_enable <= r_exMem.write_enable;
      r_memWb.pc_to_reg    <= r_exMem.pc_to_reg;
      r_memWb.rd           <= r_exMem.rd;
    end
  end

  assign bus.pc_write        = reset && w_run && !w_idStall;
  assign bus.ifid_write      = reset && w_run && !w_idStall;
  assign bus.id_stall        = w_idStall;
  assign bus.ex_alu_src      = r_idEx.alu_src;
  assign bus.ex_alu_op       = r_idEx.alu_op;
  assign bus.ex_is_branch    = r_idEx.is_branch;
  assign bus.ex_is_jal       = r_idEx.is_jal;
  assign bus.ex_is_jalr      = r_idEx.is_jalr;
  assign bus.mem_mem_read    = r_exMem.mem_read;
  assign bus.mem_mem_write   = r_exMem.mem_write;
  assign bus.wb_mem_to_reg   = r_memWb.mem_to_reg;
  assign bus.wb_write_enable = r_memWb.write_enable;
  assign bus.wb_pc_to_reg    = r_memWb.pc_to_reg;
  assign bus.wb_rd           = r_memWb.rd;
  assign bus.is_halted       = (r_state == ST_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perfStallCnt;
  logic [31:0] r_perfFlushCnt;
  logic        w_flushAccepted;

  assign w_flushAccepted = w_run && bus.ex_flush;

  // Both events require RUN, so the counters freeze naturally once halted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perfStallCnt <= '0;
      r_perfFlushCnt <= '0;
    end else begin
      if (w_idStall && (r_perfStallCnt != '1)) begin
        r_perfStallCnt <= r_perfStallCnt + 32'd1;
      end
      if (w_flushAccepted && (r_perfFlushCnt != '1)) begin
        r_perfFlushCnt <= r_perfFlushCnt + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = r_perfStallCnt;
  assign bus.perf_flush_cnt = r_perfFlushCnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (hazards, flush, halt drain, reset).
// Also checks the flush counter when built with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  // exCtrl = {alu_src, alu_op[1:0], is_branch, is_jal, is_jalr}
  localparam logic [5:0] EX_BUBBLE = 6'b000000;
  localparam logic [5:0] EX_LDST   = 6'b100000;
  localparam logic [5:0] EX_ARITH  = 6'b010000;
  localparam logic [5:0] EX_BRANCH = 6'b001100;
  localparam logic [5:0] EX_JAL    = 6'b100010;
  // fetchCtrl = {pc_write, ifid_write, id_stall}
  localparam logic [2:0] F_RUN     = 3'b110;
  localparam logic [2:0] F_STALL   = 3'b001;
  localparam logic [2:0] F_OFF     = 3'b000;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  pipe_ctrl_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  pipe_ctrl_unit #(
    .XLEN(32), .REG_ADDR_W(5), .HALT_CODE(10), .DRAIN_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wire [5:0] exCtrl    = {bus.ex_alu_src, bus.ex_alu_op, bus.ex_is_branch, bus.ex_is_jal, bus.ex_is_jalr};
  wire [1:0] memCtrl   = {bus.mem_mem_read, bus.mem_mem_write};
  wire [2:0] wbCtrl    = {bus.wb_mem_to_reg, bus.wb_write_enable, bus.wb_pc_to_reg};
  wire [2:0] fetchCtrl = {bus.pc_write, bus.ifid_write, bus.id_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [6:0] opcode,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] x17,
                               input logic flush);
    bus.id_valid  = valid;
    bus.id_opcode = opcode;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
    bus.id_x17    = x17;
    bus.ex_flush  = flush;
    #1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd2, 5'd3, 32'd10, 1'b0);
    tick();
    tick();
    testsRun++; if (exCtrl !== EX_BUBBLE) begin testsFailed++; $display("[TB] FAIL reset_ex: got %b expected %b", exCtrl, EX_BUBBLE); end
    testsRun++; if ({memCtrl, wbCtrl, bus.wb_rd} !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_mem_wb: got %b expected 0", {memCtrl, wbCtrl, bus.wb_rd}); end
    testsRun++; if (fetchCtrl !== F_OFF) begin testsFailed++; $display("[TB] FAIL reset_fetch: got %b expected %b", fetchCtrl, F_OFF); end
    testsRun++; if (bus.is_halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_halted: got %b expected 0", bus.is_halted); end
    reset = 1'b1;
    applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL reset_release_fetch: got %b expected %b", fetchCtrl, F_RUN); end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL lu_load_issue: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    testsRun++; if (exCtrl !== EX_LDST) begin testsFailed++; $display("[TB] FAIL lu_load_ex: got %b expected %b", exCtrl, EX_LDST); end
    applyStimulus(1'b1, OP_ARITH, 5'd5, 5'd7, 5'd6, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_STALL) begin testsFailed++; $display("[TB] FAIL lu_stall: got %b expected %b", fetchCtrl, F_STALL); end
    tick();
    testsRun++; if ({exCtrl, memCtrl} !== {EX_BUBBLE, 2'b10}) begin testsFailed++; $display("[TB] FAIL lu_bubble: got %b expected %b", {exCtrl, memCtrl}, {EX_BUBBLE, 2'b10}); end
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL lu_release: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    testsRun++; if (exCtrl !== EX_ARITH) begin testsFailed++; $display("[TB] FAIL lu_add_ex: got %b expected %b", exCtrl, EX_ARITH); end
    testsRun++; if ({wbCtrl, bus.wb_rd} !== {3'b110, 5'd5}) begin testsFailed++; $display("[TB] FAIL lu_load_wb: got %b expected %b", {wbCtrl, bus.wb_rd}, {3'b110, 5'd5}); end
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd8, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_STORE, 5'd3, 5'd8, 5'd0, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_STALL) begin testsFailed++; $display("[TB] FAIL lu_store_rs2: got %b expected %b", fetchCtrl, F_STALL); end
    applyStimulus(1'b1, OP_JAL, 5'd8, 5'd0, 5'd1, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL lu_jal_no_rs1: got %b expected %b", fetchCtrl, F_RUN); end
    applyStimulus(1'b1, OP_ARITH_IMM, 5'd3, 5'd8, 5'd4, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL lu_addi_no_rs2: got %b expected %b", fetchCtrl, F_RUN); end
    idleCycles(3);
  endtask

  task automatic test_load_x0();
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_ARITH, 5'd0, 5'd0, 5'd6, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL x0_no_stall: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    testsRun++; if (exCtrl !== EX_ARITH) begin testsFailed++; $display("[TB] FAIL x0_add_ex: got %b expected %b", exCtrl, EX_ARITH); end
    idleCycles(3);
  endtask

  task automatic test_jal_store();
    applyStimulus(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 32'd0, 1'b0);
    tick();
    testsRun++; if (exCtrl !== EX_JAL) begin testsFailed++; $display("[TB] FAIL jal_ex: got %b expected %b", exCtrl, EX_JAL); end
    applyStimulus(1'b1, OP_STORE, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0);
    tick();
    testsRun++; if (exCtrl !== EX_LDST) begin testsFailed++; $display("[TB] FAIL store_ex: got %b expected %b", exCtrl, EX_LDST); end
    idleCycles(1);
    testsRun++; if ({wbCtrl, bus.wb_rd} !== {3'b011, 5'd1}) begin testsFailed++; $display("[TB] FAIL jal_wb: got %b expected %b", {wbCtrl, bus.wb_rd}, {3'b011, 5'd1}); end
    testsRun++; if (memCtrl !== 2'b01) begin testsFailed++; $display("[TB] FAIL store_mem: got %b expected 01", memCtrl); end
    tick();
    testsRun++; if ({wbCtrl, bus.wb_rd} !== 8'd0) begin testsFailed++; $display("[TB] FAIL store_wb: got %b expected 0", {wbCtrl, bus.wb_rd}); end
    idleCycles(2);
  endtask

  task automatic test_flush_halt();
    logic [31:0] flushBefore;
    flushBefore = 32'd0;
    applyStimulus(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    tick();
    testsRun++; if (exCtrl !== EX_BRANCH) begin testsFailed++; $display("[TB] FAIL branch_ex: got %b expected %b", exCtrl, EX_BRANCH); end
    applyStimulus(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd10, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
    flushBefore = bus.perf_flush_cnt;
`endif
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL flush_fetch: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    testsRun++; if ({exCtrl, bus.is_halted} !== 7'd0) begin testsFailed++; $display("[TB] FAIL flush_bubble: got %b expected 0", {exCtrl, bus.is_halted}); end
    idleCycles(4);
    testsRun++; if ({fetchCtrl, bus.is_halted} !== {F_RUN, 1'b0}) begin testsFailed++; $display("[TB] FAIL flush_stays_run: got %b expected %b", {fetchCtrl, bus.is_halted}, {F_RUN, 1'b0}); end
`ifdef PIPE_CTRL_PERF_EN
    testsRun++; if (bus.perf_flush_cnt !== flushBefore + 32'd1) begin testsFailed++; $display("[TB] FAIL perf_flush: got %0d expected %0d", bus.perf_flush_cnt, flushBefore + 32'd1); end
`endif
  endtask

  task automatic test_non_halt_ecall();
    applyStimulus(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd5, 1'b0);
    tick();
    testsRun++; if (exCtrl !== EX_BUBBLE) begin testsFailed++; $display("[TB] FAIL ecall5_bubble: got %b expected %b", exCtrl, EX_BUBBLE); end
    idleCycles(4);
    testsRun++; if ({fetchCtrl, bus.is_halted} !== {F_RUN, 1'b0}) begin testsFailed++; $display("[TB] FAIL ecall5_run: got %b expected %b", {fetchCtrl, bus.is_halted}, {F_RUN, 1'b0}); end
  endtask

  task automatic test_ecall_halt();
    applyStimulus(1'b1, OP_ARITH_IMM, 5'd0, 5'd0, 5'd17, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd10, 1'b0);
    testsRun++; if (fetchCtrl !== F_STALL) begin testsFailed++; $display("[TB] FAIL ecall_ex_stall: got %b expected %b", fetchCtrl, F_STALL); end
    tick();
    testsRun++; if (fetchCtrl !== F_STALL) begin testsFailed++; $display("[TB] FAIL ecall_mem_stall: got %b expected %b", fetchCtrl, F_STALL); end
    tick();
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL ecall_issue: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    testsRun++; if ({fetchCtrl, exCtrl, bus.is_halted} !== 10'd0) begin testsFailed++; $display("[TB] FAIL drain_entry: got %b expected 0", {fetchCtrl, exCtrl, bus.is_halted}); end
    tick();
    tick();
    testsRun++; if (bus.is_halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_early: got %b expected 0", bus.is_halted); end
    applyStimulus(1'b1, OP_ARITH, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tick();
    testsRun++; if ({bus.is_halted, fetchCtrl} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL halt_exact: got %b expected 1000", {bus.is_halted, fetchCtrl}); end
    tick();
    testsRun++; if ({bus.is_halted, exCtrl} !== {1'b1, EX_BUBBLE}) begin testsFailed++; $display("[TB] FAIL halt_hold: got %b expected %b", {bus.is_halted, exCtrl}, {1'b1, EX_BUBBLE}); end
  endtask

  task automatic test_reset_drain();
    reset = 1'b0;
    idleCycles(1);
    reset = 1'b1;
    testsRun++; if (bus.is_halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL halted_cleared: got %b expected 0", bus.is_halted); end
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd4, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd10, 1'b0);
    tick();
    idleCycles(1);
    testsRun++; if ({wbCtrl, bus.wb_rd, bus.is_halted} !== {3'b110, 5'd4, 1'b0}) begin testsFailed++; $display("[TB] FAIL rd_pre_reset_wb: got %b expected %b", {wbCtrl, bus.wb_rd, bus.is_halted}, {3'b110, 5'd4, 1'b0}); end
    reset = 1'b0;
    #1;
    testsRun++; if (fetchCtrl !== F_OFF) begin testsFailed++; $display("[TB] FAIL rd_reset_fetch: got %b expected %b", fetchCtrl, F_OFF); end
    tick();
    testsRun++; if ({exCtrl, memCtrl, wbCtrl, bus.wb_rd, bus.is_halted} !== 17'd0) begin testsFailed++; $display("[TB] FAIL rd_cleared: got %b expected 0", {exCtrl, memCtrl, wbCtrl, bus.wb_rd, bus.is_halted}); end
    tick();
    testsRun++; if (bus.is_halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_no_halt: got %b expected 0", bus.is_halted); end
    reset = 1'b1;
    applyStimulus(1'b1, OP_ARITH, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    testsRun++; if (fetchCtrl !== F_RUN) begin testsFailed++; $display("[TB] FAIL rd_resume_fetch: got %b expected %b", fetchCtrl, F_RUN); end
    tick();
    testsRun++; if (exCtrl !== EX_ARITH) begin testsFailed++; $display("[TB] FAIL rd_resume_ex: got %b expected %b", exCtrl, EX_ARITH); end
    idleCycles(1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    test_reset();
    test_load_use();
    test_load_x0();
    test_jal_store();
    test_flush_halt();
    test_non_halt_ecall();
    test_ecall_halt();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
